// File: rtl/vram_req_sched_pkg.sv
// Shared VRAM types: address/word widths, ack-pipeline source tags and read latency.
package vram_req_sched_pkg;

   typedef logic [15:0] addr_t;
   typedef logic [15:0] word_t;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_VGEN,
      SRC_REGS,
      SRC_BLIT
   } vram_src_t;

   localparam int unsigned VRAM_ACK_LAT = 2;

endpackage

// File: rtl/vram_req_sched.sv
// Single-port VRAM scheduler: video gen > starved blit > regs > blit, one registered command
// per cycle, with requester acks aligned to VRAM read data.
module vram_req_sched
   import vram_req_sched_pkg::*;
#(
   parameter bit          EN_BLIT     = 1'b1,
   parameter int unsigned BLIT_STARVE = 7
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic        vgen_sel_i,
   input  addr_t       vgen_addr_i,
   input  logic        regs_sel_i,
   input  logic        regs_wr_i,
   input  logic [3:0]  regs_wr_mask_i,
   input  addr_t       regs_addr_i,
   input  word_t       regs_data_i,
   output logic        regs_ack_o,
   input  logic        blit_sel_i,
   input  logic        blit_wr_i,
   input  logic [3:0]  blit_wr_mask_i,
   input  addr_t       blit_addr_i,
   input  word_t       blit_data_i,
   output logic        blit_ack_o,
   output logic        vram_sel_o,
   output logic        vram_wr_o,
   output logic [3:0]  vram_wr_mask_o,
   output addr_t       vram_addr_o,
   output word_t       vram_data_o
);

   logic      w_blit_sel;
   logic      w_starved;
   logic      r_regs_pend;
   vram_src_t w_win;
   vram_src_t r_src [VRAM_ACK_LAT];

   generate
      if (EN_BLIT) begin : g_blit
         logic [3:0] r_starve_cnt;

         assign w_blit_sel = blit_sel_i;
         assign w_starved  = (r_starve_cnt == 4'(BLIT_STARVE));

         always_ff @(posedge clk or posedge reset_i) begin
            if (reset_i) begin
               r_starve_cnt <= '0;
            end else if (!blit_sel_i) begin
               r_starve_cnt <= '0;
            end else if (w_win == SRC_VGEN) begin
               r_starve_cnt <= r_starve_cnt;
            end else if (w_win == SRC_BLIT) begin
               r_starve_cnt <= '0;
            end else if (r_starve_cnt != 4'(BLIT_STARVE)) begin
               r_starve_cnt <= r_starve_cnt + 4'd1;
            end
         end
      end else begin : g_no_blit
         assign w_blit_sel = 1'b0;
         assign w_starved  = 1'b0;
      end
   endgenerate

   always_comb begin
      w_win = SRC_NONE;
      if (vgen_sel_i) begin
         w_win = SRC_VGEN;
      end else if (w_blit_sel && w_starved) begin
         w_win = SRC_BLIT;
      end else if (regs_sel_i && !r_regs_pend) begin
         w_win = SRC_REGS;
      end else if (w_blit_sel) begin
         w_win = SRC_BLIT;
      end
   end

   // Acks come from the tail of the source pipeline, the cycle read data is valid.
   assign regs_ack_o = (r_src[VRAM_ACK_LAT-1] == SRC_REGS);
   assign blit_ack_o = (r_src[VRAM_ACK_LAT-1] == SRC_BLIT);

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         for (int unsigned i = 0; i < VRAM_ACK_LAT; i++) begin
            r_src[i] <= SRC_NONE;
         end
         r_regs_pend    <= 1'b0;
         vram_sel_o     <= 1'b0;
         vram_wr_o      <= 1'b0;
         vram_wr_mask_o <= '0;
         vram_addr_o    <= '0;
         vram_data_o    <= '0;
      end else begin
         r_src[0] <= w_win;
         for (int unsigned i = 1; i < VRAM_ACK_LAT; i++) begin
            r_src[i] <= r_src[i-1];
         end

         if (w_win == SRC_REGS) begin
            r_regs_pend <= 1'b1;
         end else if (regs_ack_o) begin
            r_regs_pend <= 1'b0;
         end

         case (w_win)
            SRC_VGEN: begin
               vram_sel_o     <= 1'b1;
               vram_wr_o      <= 1'b0;
               vram_wr_mask_o <= '0;
               vram_addr_o    <= vgen_addr_i;
               vram_data_o    <= '0;
            end
            SRC_REGS: begin
               vram_sel_o     <= 1'b1;
               vram_wr_o      <= regs_wr_i;
               vram_wr_mask_o <= regs_wr_mask_i;
               vram_addr_o    <= regs_addr_i;
               vram_data_o    <= regs_data_i;
            end
            SRC_BLIT: begin
               vram_sel_o     <= 1'b1;
               vram_wr_o      <= blit_wr_i;
               vram_wr_mask_o <= blit_wr_mask_i;
               vram_addr_o    <= blit_addr_i;
               vram_data_o    <= blit_data_i;
            end
            default: begin
               vram_sel_o     <= 1'b0;
               vram_wr_o      <= 1'b0;
               vram_wr_mask_o <= '0;
               vram_addr_o    <= '0;
               vram_data_o    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_req_sched.sv
// Bench for vram_req_sched: one blit-enabled and one blit-disabled instance on shared stimulus,
// both checked every cycle against a priority/latency reference model.
module tb_vram_req_sched;

   localparam int STARVE = 7;
   localparam int NONE = 0, VG = 1, RG = 2, BL = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        vgen_sel;
   logic [15:0] vgen_addr;
   logic        regs_sel, regs_wr;
   logic [3:0]  regs_mask;
   logic [15:0] regs_addr, regs_data;
   logic        blit_sel, blit_wr;
   logic [3:0]  blit_mask;
   logic [15:0] blit_addr, blit_data;

   logic [1:0]  o_sel, o_wr, o_rack, o_back;
   logic [3:0]  o_mask [2];
   logic [15:0] o_addr [2];
   logic [15:0] o_data [2];

   int checks = 0;
   int errors = 0;

   // reference model state, index 0 = blit enabled, 1 = blit disabled
   int m_pend [2];
   int m_cnt  [2];
   int m_w1   [2];
   int m_w2   [2];
   int m_blit_grants = 0;
   int o_blit_acks   = 0;
   int nb_blit_acks  = 0;

   always #5 clk = ~clk;

   vram_req_sched #(.EN_BLIT(1'b1), .BLIT_STARVE(STARVE)) u_dut (
      .clk(clk), .reset_i(rst),
      .vgen_sel_i(vgen_sel), .vgen_addr_i(vgen_addr),
      .regs_sel_i(regs_sel), .regs_wr_i(regs_wr), .regs_wr_mask_i(regs_mask),
      .regs_addr_i(regs_addr), .regs_data_i(regs_data), .regs_ack_o(o_rack[0]),
      .blit_sel_i(blit_sel), .blit_wr_i(blit_wr), .blit_wr_mask_i(blit_mask),
      .blit_addr_i(blit_addr), .blit_data_i(blit_data), .blit_ack_o(o_back[0]),
      .vram_sel_o(o_sel[0]), .vram_wr_o(o_wr[0]), .vram_wr_mask_o(o_mask[0]),
      .vram_addr_o(o_addr[0]), .vram_data_o(o_data[0])
   );

   vram_req_sched #(.EN_BLIT(1'b0), .BLIT_STARVE(STARVE)) u_dut_nb (
      .clk(clk), .reset_i(rst),
      .vgen_sel_i(vgen_sel), .vgen_addr_i(vgen_addr),
      .regs_sel_i(regs_sel), .regs_wr_i(regs_wr), .regs_wr_mask_i(regs_mask),
      .regs_addr_i(regs_addr), .regs_data_i(regs_data), .regs_ack_o(o_rack[1]),
      .blit_sel_i(blit_sel), .blit_wr_i(blit_wr), .blit_wr_mask_i(blit_mask),
      .blit_addr_i(blit_addr), .blit_data_i(blit_data), .blit_ack_o(o_back[1]),
      .vram_sel_o(o_sel[1]), .vram_wr_o(o_wr[1]), .vram_wr_mask_o(o_mask[1]),
      .vram_addr_o(o_addr[1]), .vram_data_o(o_data[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = 0;
         m_cnt[k]  = 0;
         m_w1[k]   = NONE;
         m_w2[k]   = NONE;
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_sel%0d", tag, k), 32'(o_sel[k]), 0);
         check($sformatf("%s_wr%0d", tag, k), 32'(o_wr[k]), 0);
         check($sformatf("%s_mask%0d", tag, k), 32'(o_mask[k]), 0);
         check($sformatf("%s_addr%0d", tag, k), 32'(o_addr[k]), 0);
         check($sformatf("%s_data%0d", tag, k), 32'(o_data[k]), 0);
         check($sformatf("%s_rack%0d", tag, k), 32'(o_rack[k]), 0);
         check($sformatf("%s_back%0d", tag, k), 32'(o_back[k]), 0);
      end
   endtask

   // Decide this cycle's winner from the rules, advance one clock, compare every output.
   task automatic step();
      int          w  [2];
      logic        es [2];
      logic        ew [2];
      logic [3:0]  em [2];
      logic [15:0] ea [2];
      logic [15:0] ed [2];
      bit          bsel;
      for (int k = 0; k < 2; k++) begin
         bsel = blit_sel && (k == 0);
         if (vgen_sel)                           w[k] = VG;
         else if (bsel && m_cnt[k] == STARVE)    w[k] = BL;
         else if (regs_sel && m_pend[k] == 0)    w[k] = RG;
         else if (bsel)                          w[k] = BL;
         else                                    w[k] = NONE;
         es[k] = (w[k] != NONE);
         ew[k] = 1'b0; em[k] = '0; ea[k] = '0; ed[k] = '0;
         if (w[k] == VG) ea[k] = vgen_addr;
         if (w[k] == RG) begin
            ew[k] = regs_wr; em[k] = regs_mask; ea[k] = regs_addr; ed[k] = regs_data;
         end
         if (w[k] == BL) begin
            ew[k] = blit_wr; em[k] = blit_mask; ea[k] = blit_addr; ed[k] = blit_data;
         end
         if (w[k] == RG)            m_pend[k] = 1;
         else if (m_w2[k] == RG)    m_pend[k] = 0;
         if (!bsel)                 m_cnt[k] = 0;
         else if (w[k] == VG)       m_cnt[k] = m_cnt[k];
         else if (w[k] == BL)       m_cnt[k] = 0;
         else if (m_cnt[k] < STARVE) m_cnt[k] = m_cnt[k] + 1;
         if (k == 0 && w[k] == BL) m_blit_grants++;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("sel%0d", k), 32'(o_sel[k]), 32'(es[k]));
         check($sformatf("wr%0d", k), 32'(o_wr[k]), 32'(ew[k]));
         check($sformatf("mask%0d", k), 32'(o_mask[k]), 32'(em[k]));
         check($sformatf("addr%0d", k), 32'(o_addr[k]), 32'(ea[k]));
         check($sformatf("data%0d", k), 32'(o_data[k]), 32'(ed[k]));
         check($sformatf("regs_ack%0d", k), 32'(o_rack[k]), 32'(m_w1[k] == RG));
         check($sformatf("blit_ack%0d", k), 32'(o_back[k]), 32'(m_w1[k] == BL));
         m_w2[k] = m_w1[k];
         m_w1[k] = w[k];
      end
      if (o_back[0]) o_blit_acks++;
      if (o_back[1]) nb_blit_acks++;
   endtask

   initial begin
      int cnt_bad;
      int run, max_run, g0, a0, blits;

      rst = 1'b1;
      vgen_sel = 0; vgen_addr = '0;
      regs_sel = 0; regs_wr = 0; regs_mask = '0; regs_addr = '0; regs_data = '0;
      blit_sel = 0; blit_wr = 0; blit_mask = '0; blit_addr = '0; blit_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // regs read at 0x1234, no contention
      regs_sel = 1; regs_wr = 0; regs_addr = 16'h1234; regs_mask = 4'hf;
      step();
      check("t1_addr", 32'(o_addr[0]), 32'h1234);
      check("t1_wr", 32'(o_wr[0]), 0);
      step();
      check("t1_ack", 32'(o_rack[0]), 1);
      step();
      check("t1_no_regrant", 32'(o_sel[0]), 0);
      check("t1_ack_single", 32'(o_rack[0]), 0);
      regs_sel = 0;
      repeat (2) step();

      // vgen held 10 cycles while regs requests
      regs_sel = 1; regs_wr = 1; regs_addr = 16'h1abc; regs_data = 16'h5a5a; regs_mask = 4'h6;
      vgen_sel = 1;
      cnt_bad = 0;
      for (int i = 0; i < 10; i++) begin
         vgen_addr = 16'h4000 | 16'($urandom_range(0, 16'h0fff));
         step();
         if (o_sel[0] && o_addr[0] == 16'h1abc) cnt_bad++;
      end
      check("t2_regs_blocked", 32'(cnt_bad), 0);
      vgen_sel = 0;
      step();
      check("t2_regs_after_vgen", 32'(o_addr[0]), 32'h1abc);
      step();
      step();
      regs_sel = 0;
      repeat (2) step();

      // blit held 20 cycles against back-to-back regs
      g0 = m_blit_grants; a0 = o_blit_acks;
      run = 0; max_run = 0; blits = 0;
      regs_sel = 1; regs_wr = 0;
      blit_sel = 1; blit_wr = 0;
      for (int i = 0; i < 20; i++) begin
         blit_addr = 16'h8000 + 16'(i);
         regs_addr = 16'h1000 + 16'(i);
         step();
         if (o_sel[0] && o_addr[0][15]) begin
            blits++; run = 0;
         end else begin
            run++;
            if (run > max_run) max_run = run;
         end
      end
      blit_sel = 0; regs_sel = 0;
      repeat (3) step();
      check("t3_blit_gap", 32'(max_run <= STARVE), 1);
      check("t3_blit_granted", 32'(blits > 0), 1);
      check("t3_ack_count", 32'(o_blit_acks - a0), 32'(m_blit_grants - g0));

      // blit write 0x0100 / mask 0011 / data ABCD
      blit_sel = 1; blit_wr = 1; blit_mask = 4'b0011; blit_addr = 16'h0100; blit_data = 16'habcd;
      step();
      blit_sel = 0;
      check("t4_wr", 32'(o_wr[0]), 1);
      check("t4_mask", 32'(o_mask[0]), 32'b0011);
      check("t4_data", 32'(o_data[0]), 32'habcd);
      check("t4_nb_idle", 32'(o_sel[1]), 0);
      step();
      check("t4_ack", 32'(o_back[0]), 1);
      step();

      // asynchronous reset between regs grant and ack
      regs_sel = 1; regs_wr = 1; regs_addr = 16'h1555; regs_data = 16'h5555; regs_mask = 4'hf;
      step();
      check("t5_granted", 32'(o_addr[0]), 32'h1555);
      #2 rst = 1'b1;
      #1;
      check_all_zero("t5_async");
      #2 rst = 1'b0;
      model_reset();
      step();
      check("t5_no_stale_ack", 32'(o_rack[0]), 0);
      check("t5_reissue", 32'(o_addr[0]), 32'h1555);
      step();
      check("t5_ack", 32'(o_rack[0]), 1);
      regs_sel = 0;
      repeat (2) step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         vgen_sel  = ($urandom_range(0, 3) == 0);
         vgen_addr = 16'($urandom);
         blit_sel  = ($urandom_range(0, 1) == 1);
         blit_wr   = 1'($urandom);
         blit_mask = 4'($urandom);
         blit_addr = 16'($urandom);
         blit_data = 16'($urandom);
         if (regs_sel && o_rack[0]) begin
            regs_sel = ($urandom_range(0, 3) == 0);
         end else if (!regs_sel && $urandom_range(0, 2) == 0) begin
            regs_sel  = 1;
            regs_wr   = 1'($urandom);
            regs_mask = 4'($urandom);
            regs_addr = 16'($urandom);
            regs_data = 16'($urandom);
         end
         step();
      end
      vgen_sel = 0; blit_sel = 0; regs_sel = 0;
      repeat (3) step();

      check("nb_blit_acks", 32'(nb_blit_acks), 0);
      check("blit_ack_total", 32'(o_blit_acks), 32'(m_blit_grants));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
